// File: rtl/deskew_matrix.sv
// rtl/deskew_matrix.sv - realigns a diagonal-wavefront lane stream into a held SIZE x SIZE matrix
// Optional pad-slot check enabled by defining DESKEW_PAD_CHECK_EN.
module deskew_matrix #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 3
) (
  input  logic                                     clock,
  input  logic                                     nreset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [SIZE*WIDTH-1:0]                    in_data,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]     Mout,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     pad_err
);

  localparam int BEATS = 2 * SIZE - 1;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mat_q, mat_d;
  logic                                 accept;
  logic                                 last_beat;

  // A full matrix is released the same cycle the next one may start.
  assign in_ready  = (state_q != S_FULL) || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CW'(BEATS - 1));
  assign out_valid = (state_q == S_FULL);
  assign Mout      = mat_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_FULL && out_ready) begin
      state_d = S_IDLE;
    end
    if (accept) begin
      if (last_beat) begin
        state_d = S_FULL;
        cnt_d   = '0;
      end else begin
        state_d = S_COLLECT;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // Beat k carries row k-t on lane t; each element is written exactly once per matrix.
  always_comb begin
    mat_d = mat_q;
    for (int r = 0; r < SIZE; r++) begin
      for (int t = 0; t < SIZE; t++) begin
        if (accept && (int'(cnt_q) == r + t)) begin
          mat_d[r][t] = in_data[t*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
    end
  end

`ifdef DESKEW_PAD_CHECK_EN
  logic pad_err_q;
  logic pad_hit;

  always_comb begin
    pad_hit = 1'b0;
    for (int t = 0; t < SIZE; t++) begin
      if ((int'(cnt_q) < t || int'(cnt_q) >= t + SIZE) &&
          (in_data[t*WIDTH +: WIDTH] != '0)) begin
        pad_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pad_err_q <= 1'b0;
    end else if (accept && pad_hit) begin
      pad_err_q <= 1'b1;
    end
  end

  assign pad_err = pad_err_q;
`else
  assign pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_deskew_matrix.sv
// tb/tb_deskew_matrix.sv - self-checking bench for deskew_matrix
// Pad-error expectations follow DESKEW_PAD_CHECK_EN.
module tb_deskew_matrix;

  typedef int mat_t [3][3];

  typedef struct {
    logic        v;
    logic [11:0] d;
    logic        ordy;
    logic        ir;
    logic        ov;
    int          m;
  } vec_t;

`ifdef DESKEW_PAD_CHECK_EN
  localparam logic PADX = 1'b1;
`else
  localparam logic PADX = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               nreset;
  logic               in_valid;
  logic               in_ready;
  logic [11:0]        in_data;
  logic [2:0][2:0][3:0] Mout;
  logic               out_valid;
  logic               out_ready;
  logic               pad_err;

  int n_checks = 0;
  int n_fail   = 0;

  mat_t ma = '{'{1, 2, 3}, '{7, 6, 5}, '{8, 9, 4}};
  mat_t mt = '{'{1, 7, 8}, '{2, 6, 9}, '{3, 5, 4}};
  logic [11:0] sa [5] = '{12'h001, 12'h027, 12'h368, 12'h590, 12'h400};
  logic [11:0] st [5] = '{12'h001, 12'h072, 12'h863, 12'h950, 12'h400};
  vec_t tbl[$];

  deskew_matrix #(.WIDTH(4), .SIZE(3)) dut (
    .clock    (clock),
    .nreset   (nreset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .Mout     (Mout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pad_err  (pad_err)
  );

  always #5 clock = ~clock;

  function automatic logic [35:0] pack(input mat_t m);
    logic [35:0] p;
    p = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[(r*3+c)*4 +: 4] = 4'(m[r][c]);
    return p;
  endfunction

  function automatic logic [11:0] skew_beat(input mat_t m, input int k);
    logic [11:0] b;
    b = '0;
    for (int t = 0; t < 3; t++)
      if (k - t >= 0 && k - t < 3) b[t*4 +: 4] = 4'(m[k-t][t]);
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] d, input logic ordy);
    @(negedge clock);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic add(input logic v, input logic [11:0] d, input logic ordy,
                     input logic ir, input logic ov, input int m);
    vec_t e;
    e.v = v; e.d = d; e.ordy = ordy; e.ir = ir; e.ov = ov; e.m = m;
    tbl.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] exp_q[$];
    mat_t cur;
    int   beat, sent, got;
    bit   pend;

    nreset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset Mout", 64'(Mout), 0);
    chk("reset pad_err", pad_err, 0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;

    // Basic followed by back-to-back transpose
    for (int k = 0; k < 5; k++) add(1, sa[k], 1, 1, 0, 0);
    add(1, st[0], 1, 1, 1, 1);
    for (int k = 1; k < 5; k++) add(1, st[k], 1, 1, 0, 0);
    add(0, 12'hABC, 1, 1, 1, 2);
    add(0, 12'h000, 1, 1, 0, 0);
    // Gaps carrying junk that must be ignored
    add(1, sa[0], 1, 1, 0, 0);
    add(1, sa[1], 1, 1, 0, 0);
    add(0, 12'hFFF, 1, 1, 0, 0);
    add(1, sa[2], 1, 1, 0, 0);
    add(1, sa[3], 1, 1, 0, 0);
    add(0, 12'hFFF, 1, 1, 0, 0);
    add(1, sa[4], 1, 1, 0, 0);
    // Backpressure: four stalled cycles, then handover
    for (int k = 0; k < 4; k++) add(1, st[0], 0, 0, 1, 1);
    add(1, st[0], 1, 1, 1, 1);
    for (int k = 1; k < 5; k++) add(1, st[k], 1, 1, 0, 0);
    add(0, 12'h000, 1, 1, 1, 2);
    add(0, 12'h000, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].ordy);
      chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d pad_err", i), pad_err, 0);
      if (tbl[i].m == 1) chk($sformatf("tbl%0d Mout", i), 64'(Mout), 64'(pack(ma)));
      else if (tbl[i].m == 2) chk($sformatf("tbl%0d Mout", i), 64'(Mout), 64'(pack(mt)));
    end

    // Reset mid-matrix
    drive(1, sa[0], 1);
    drive(1, sa[1], 1);
    drive(1, sa[2], 1);
    @(posedge clock);
    #2;
    in_valid = 1'b0;
    nreset = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst Mout", 64'(Mout), 0);
    chk("midrst pad_err", pad_err, 0);
    @(negedge clock);
    nreset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, sa[k], 1);
      chk($sformatf("postrst beat%0d out_valid", k), out_valid, 0);
    end
    drive(0, 12'h000, 1);
    chk("postrst out_valid", out_valid, 1);
    chk("postrst Mout", 64'(Mout), 64'(pack(ma)));

    // Pad slot carrying nonzero data
    drive(0, 12'h000, 1);
    drive(1, 12'h0F1, 1);
    chk("pad before edge", pad_err, 0);
    for (int k = 1; k < 5; k++) begin
      drive(1, sa[k], 1);
      chk($sformatf("pad beat%0d pad_err", k), pad_err, PADX);
    end
    drive(0, 12'h000, 1);
    chk("pad out_valid", out_valid, 1);
    chk("pad Mout", 64'(Mout), 64'(pack(ma)));
    chk("pad sticky", pad_err, PADX);
    drive(0, 12'h000, 1);
    chk("pad sticky idle", pad_err, PADX);
    nreset = 1'b0;
    #1;
    chk("pad cleared", pad_err, 0);
    @(negedge clock);
    nreset = 1'b1;

    // Random matrices, random valid gaps and backpressure, scoreboarded
    beat = 0; sent = 0; got = 0; pend = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) cur[r][c] = int'($urandom_range(0, 15));
    for (int cyc = 0; cyc < 6000 && got < 40; cyc++) begin
      logic v;
      v = (sent < 40) && ($urandom_range(0, 9) < 7);
      drive(v, v ? skew_beat(cur, beat) : 12'($urandom), $urandom_range(0, 9) < 6);
      if (pend) begin
        chk($sformatf("rnd%0d latency", sent), out_valid, 1);
        pend = 0;
      end
      if (in_ready !== (!out_valid || out_ready)) chk("rnd in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd spurious out_valid", out_valid, 0);
        end else begin
          chk($sformatf("rnd%0d Mout", got), 64'(Mout), 64'(exp_q.pop_front()));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        beat++;
        if (beat == 5) begin
          exp_q.push_back(pack(cur));
          pend = 1;
          beat = 0;
          sent++;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) cur[r][c] = int'($urandom_range(0, 15));
        end
      end
    end
    chk("rnd matrices received", got, 40);
    chk("rnd pad_err", pad_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deskew_matrix.md
# deskew_matrix

Output-side companion to the systolic array's skewed input feeder. It receives the diagonal-wavefront stream that leaves the array, one lane per column, each lane delayed one beat more than the previous lane. It realigns the stream into a SIZE x SIZE matrix and holds that matrix until a downstream consumer accepts it. Valid/ready on both sides lets back-to-back matrices flow at one beat per cycle.

## Interface
- WIDTH, 4, bits per matrix element
- SIZE, 3, matrix dimension; one stream lane per column
- clock  input  1  rising-edge clock
- nreset  input  1  asynchronous, active-low reset
- in_valid  input  1  beat present on in_data
- in_ready  output  1  block can accept a beat
- in_data  input  SIZE*WIDTH  lane t at bits [t*WIDTH +: WIDTH]
- Mout  output  [WIDTH-1:0] x [SIZE-1:0][SIZE-1:0]  registered matrix, Mout[row][col]
- out_valid  output  1  Mout holds a complete matrix
- out_ready  input  1  consumer takes Mout
- pad_err  output  1  sticky: nonzero data seen in a pad slot (see Configuration)

## Operation
- One matrix is exactly 2*SIZE-1 accepted beats, numbered k = 0..2*SIZE-2. A beat is accepted when in_valid && in_ready.
- At beat k, lane t carries element row r = k-t if 0 <= r < SIZE. Otherwise the slot is pad. The block writes Mout[k-t][t] <= lane t.
- Every (r,t) is written exactly once per matrix, so there is no clear between matrices.
- Beat counter: range 0..2*SIZE-2, width $clog2(2*SIZE-1). It advances only on an accepted beat, so in_valid gaps are allowed and the counter holds across them.
- FSM states:
  - IDLE: counter = 0, out_valid = 0. An accepted beat writes beat 0 and goes to COLLECT with counter = 1.
  - COLLECT: an accepted beat writes and increments the counter. When beat 2*SIZE-2 is accepted, the counter returns to 0 and the FSM goes to FULL.
  - FULL: out_valid = 1. When out_ready = 1, go to IDLE, or to COLLECT if a beat is accepted in the same cycle.
- in_ready = (state != FULL) || out_ready, which gives zero-bubble handover.
- Simultaneous out_ready and accepted beat in FULL:
  - The consumer samples the old Mout during that cycle.
  - Beat 0 of the next matrix writes Mout[0][0] at the same edge.
  - Next state is COLLECT with counter = 1.
- Mout may change while out_valid = 0 (partial matrix). Consumers sample it only with out_valid.

## Timing
- Reset (async assert):
  - state = IDLE, counter = 0.
  - Mout all zeros, out_valid = 0, in_ready = 1, pad_err = 0.
- Latency: out_valid rises the cycle after the edge that accepts beat 2*SIZE-2.
- Throughput: one matrix per 2*SIZE-1 cycles when out_ready is held high.
- Reset mid-matrix discards the partial matrix. The next accepted beat after reset release is beat 0.
- in_data is ignored while in_valid = 0 or in_ready = 0.

## Configuration
- Macro: DESKEW_PAD_CHECK_EN.
- Defined:
  - Every accepted beat's pad slots are compared to zero.
  - Any nonzero pad sets pad_err on the next edge.
  - pad_err stays 1 until reset.
  - The check does not change data flow.
- Undefined: pad_err is tied to 0 and no compare logic is built.

## Test plan
All scenarios use WIDTH=4, SIZE=3 and the source matrix rows 1 2 3 / 7 6 5 / 8 9 4. The stream is 12'h001, 12'h027, 12'h368, 12'h590, 12'h400 (lane 0 is the low nibble).
- Basic: stream sent on consecutive cycles, out_ready=1. Required response:
  - out_valid pulses one cycle after the 5th beat.
  - Mout rows = {1,2,3},{7,6,5},{8,9,4}.
  - pad_err=0.
- Gaps: in_valid=0 cycles are inserted between beats 1/2 and 3/4. Mout and its out_valid timing relative to the last beat are identical to Basic.
- Backpressure: out_ready=0 for 4 cycles after out_valid rises. Required response:
  - in_ready=0 and Mout stable through the stall.
  - Next matrix's beat 0 is accepted on the cycle out_ready rises.
- Back-to-back: two matrices sent with no idle cycles, the second being the transpose, with out_ready=1. Required response:
  - out_valid rises at cycle 6 and at cycle 11.
  - Second Mout = {1,7,8},{2,6,9},{3,5,4}.
- Reset mid-matrix: nreset pulsed after beat 2, then the full stream is sent. Required response:
  - Outputs reach their reset values immediately.
  - The new matrix assembles correctly.
- Pad check (macro defined): beat 0 = 12'h0F1. pad_err=1 from the next cycle until reset. With the macro undefined, pad_err stays 0.
